// File: rtl/contador_programa.sv
// contador_programa: program counter and subroutine sequencer.
// Produces the instruction address every cycle and drives an external
// return-address stack (activa/push/entradaDatos). The stack has no reset
// and no full/empty flags, so nesting depth is tracked here and the
// sequencer halts in ERROR on overflow or underflow.
// Optional interrupt support (irq, inst_reti, VECTOR_IRQ, mask bit) is
// compiled in when the macro INTERRUPCION_EN is defined.
module contador_programa #(
  parameter int ANCHO_PC        = 10,
  parameter int PROFUNDIDAD     = 511,
  parameter int VECTOR_REINICIO = 0,
`ifdef INTERRUPCION_EN
  parameter int VECTOR_IRQ      = 4,
`endif
  localparam int ANCHO_PROF     = $clog2(PROFUNDIDAD + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  habilita,
  input  logic                  inst_salto,
  input  logic                  inst_call,
  input  logic                  inst_ret,
`ifdef INTERRUPCION_EN
  input  logic                  irq,
  input  logic                  inst_reti,
`endif
  input  logic [ANCHO_PC-1:0]   dir_salto,
  input  logic [ANCHO_PC-1:0]   pila_salida,
  output logic [ANCHO_PC-1:0]   pc,
  output logic                  pc_valido,
  output logic                  pila_activa,
  output logic                  pila_push,
  output logic [ANCHO_PC-1:0]   pila_dato,
  output logic [ANCHO_PROF-1:0] profundidad,
  output logic [1:0]            error_pila
);

  typedef enum logic [1:0] {
    EST_INICIO  = 2'd0,
    EST_EJECUTA = 2'd1,
    EST_ERROR   = 2'd2
  } estado_t;

  // One decoded action per cycle; shared by next-state and output logic.
  typedef enum logic [2:0] {
    ACC_NINGUNA     = 3'd0,
    ACC_INC         = 3'd1,
    ACC_SALTO       = 3'd2,
    ACC_CALL        = 3'd3,
    ACC_RET         = 3'd4,
    ACC_IRQ         = 3'd5,
    ACC_DESBORDE    = 3'd6,
    ACC_SUBDESBORDE = 3'd7
  } accion_t;

  estado_t               r_estado;
  estado_t               w_estado_sig;
  accion_t               w_accion;
  logic [ANCHO_PC-1:0]   r_pc;
  logic [ANCHO_PC-1:0]   w_pc_sig;
  logic [ANCHO_PC-1:0]   w_pc_mas1;
  logic                  r_pc_valido;
  logic [ANCHO_PROF-1:0] r_prof;
  logic [ANCHO_PROF-1:0] w_prof_sig;
  logic [1:0]            r_error;
  logic [1:0]            w_error_sig;
  logic                  w_lleno;
  logic                  w_vacio;
  logic                  w_ret;
  logic                  w_irq;

  assign w_pc_mas1 = r_pc + {{(ANCHO_PC-1){1'b0}}, 1'b1};
  assign w_lleno   = (r_prof == ANCHO_PROF'(PROFUNDIDAD));
  assign w_vacio   = (r_prof == {ANCHO_PROF{1'b0}});

`ifdef INTERRUPCION_EN
  logic r_mascara;

  assign w_ret = inst_ret | inst_reti;
  assign w_irq = irq & ~r_mascara;

  // Interrupt mask: set on interrupt entry, cleared by reti or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mascara <= 1'b0;
    end else if (w_accion == ACC_IRQ) begin
      r_mascara <= 1'b1;
    end else if (w_accion == ACC_RET && inst_reti) begin
      r_mascara <= 1'b0;
    end else begin
      r_mascara <= r_mascara;
    end
  end
`else
  assign w_ret = inst_ret;
  assign w_irq = 1'b0;
`endif

  // Request decode: only EJECUTA with habilita=1 acts; priority irq > ret > call > salto.
  always_comb begin
    w_accion = ACC_NINGUNA;
    if (reset) begin
      w_accion = ACC_NINGUNA;
    end else if (r_estado == EST_EJECUTA && habilita) begin
      if (w_irq) begin
        w_accion = w_lleno ? ACC_DESBORDE : ACC_IRQ;
      end else if (w_ret) begin
        w_accion = w_vacio ? ACC_SUBDESBORDE : ACC_RET;
      end else if (inst_call) begin
        w_accion = w_lleno ? ACC_DESBORDE : ACC_CALL;
      end else if (inst_salto) begin
        w_accion = ACC_SALTO;
      end else begin
        w_accion = ACC_INC;
      end
    end else begin
      w_accion = ACC_NINGUNA;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= EST_INICIO;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // FSM next state: INICIO lasts one cycle, ERROR is left only through reset.
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      EST_INICIO: w_estado_sig = EST_EJECUTA;
      EST_EJECUTA: begin
        if (w_accion == ACC_DESBORDE || w_accion == ACC_SUBDESBORDE) begin
          w_estado_sig = EST_ERROR;
        end else begin
          w_estado_sig = EST_EJECUTA;
        end
      end
      EST_ERROR: w_estado_sig = EST_ERROR;
      default:   w_estado_sig = EST_ERROR;
    endcase
  end

  // FSM outputs: stack controls and next values of pc, depth and error flags.
  always_comb begin
    pila_activa = 1'b0;
    pila_push   = 1'b0;
    pila_dato   = w_pc_mas1;
    w_pc_sig    = r_pc;
    w_prof_sig  = r_prof;
    w_error_sig = r_error;
    case (w_accion)
      ACC_INC:   w_pc_sig = w_pc_mas1;
      ACC_SALTO: w_pc_sig = dir_salto;
      ACC_CALL: begin
        pila_activa = 1'b1;
        pila_push   = 1'b1;
        w_pc_sig    = dir_salto;
        w_prof_sig  = r_prof + ANCHO_PROF'(1);
      end
      ACC_IRQ: begin
        // The interrupted instruction itself is resumed, so push pc, not pc+1.
        pila_activa = 1'b1;
        pila_push   = 1'b1;
        pila_dato   = r_pc;
`ifdef INTERRUPCION_EN
        w_pc_sig    = ANCHO_PC'(VECTOR_IRQ);
`else
        w_pc_sig    = r_pc;
`endif
        w_prof_sig  = r_prof + ANCHO_PROF'(1);
      end
      ACC_RET: begin
        // pila_salida already shows the top of stack; no wait state needed.
        pila_activa = 1'b1;
        pila_push   = 1'b0;
        w_pc_sig    = pila_salida;
        w_prof_sig  = r_prof - ANCHO_PROF'(1);
      end
      ACC_DESBORDE:    w_error_sig = r_error | 2'b01;
      ACC_SUBDESBORDE: w_error_sig = r_error | 2'b10;
      default: begin
        w_pc_sig    = r_pc;
        w_prof_sig  = r_prof;
        w_error_sig = r_error;
      end
    endcase
  end

  // Datapath registers: pc, valid flag, nesting depth and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= ANCHO_PC'(VECTOR_REINICIO);
      r_pc_valido <= 1'b0;
      r_prof      <= {ANCHO_PROF{1'b0}};
      r_error     <= 2'b00;
    end else begin
      r_pc        <= w_pc_sig;
      r_pc_valido <= (w_estado_sig == EST_EJECUTA);
      r_prof      <= w_prof_sig;
      r_error     <= w_error_sig;
    end
  end

  assign pc          = r_pc;
  assign pc_valido   = r_pc_valido;
  assign profundidad = r_prof;
  assign error_pila  = r_error;

endmodule

// File: doc/contador_programa.md
Name: contador_programa

Overview:
- Program-counter and subroutine sequencer for the processor.
- Produces the instruction address every cycle and decodes jump, call and return requests.
- Directly drives the return-address stack: its activa, push and entradaDatos inputs.
- Consumes the stack's registered top-of-stack output (salidaDatos) on returns.
- Tracks stack depth itself and halts on overflow or underflow, because the stack has no reset and no full/empty indication.

Parameters:
- ANCHO_PC, 10: width of the program counter and of each stack word (the stack's DATA equals ANCHO_PC).
- PROFUNDIDAD, 511: maximum number of nested calls held on the stack.
- VECTOR_REINICIO, 0: PC value loaded by reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- habilita  input  1  1 = advance; 0 = stall (PC held, no stack operation).
- inst_salto  input  1  unconditional jump to dir_salto.
- inst_call  input  1  subroutine call to dir_salto.
- inst_ret  input  1  return from subroutine.
- dir_salto  input  ANCHO_PC  jump/call target.
- pila_salida  input  ANCHO_PC  stack top-of-stack (registered in the stack).
- pc  output  ANCHO_PC  current instruction address (registered).
- pc_valido  output  1  pc is a fetchable address.
- pila_activa  output  1  stack enable (combinational).
- pila_push  output  1  1 = push, 0 = pop (combinational).
- pila_dato  output  ANCHO_PC  return address to push = pc+1 (combinational).
- profundidad  output  ceil(log2(PROFUNDIDAD+1))  current nesting depth (registered).
- error_pila  output  2  bit0 = overflow, bit1 = underflow (sticky).

Behaviour:
Reset and clocking
- Only clock and reset are clk and reset, synchronous active-high; all registers update on posedge clk.
- Reset values: pc=VECTOR_REINICIO, pc_valido=0, profundidad=0, error_pila=0, state INICIO.
- While reset=1: pila_activa=0, so no stack access occurs during or on the reset edge.
- The stack pointer is not reset. Only relative LIFO order matters, so stale stack contents are never read: a ret at depth 0 is an underflow.

State machine: INICIO, EJECUTA, ERROR.
- INICIO: one cycle. pc_valido=0, no stack ops. Unconditionally goes to EJECUTA; pc unchanged.
- EJECUTA: pc_valido=1. When habilita=0, nothing changes and pila_activa=0. When habilita=1, the first matching row applies (priority order):
  - ret, depth=0: no pop, set error_pila[1], go to ERROR, pc held.
  - ret, depth>0: pila_activa=1, pila_push=0, pc<=pila_salida, profundidad-1.
  - call, depth=PROFUNDIDAD: no push, set error_pila[0], go to ERROR, pc held.
  - call, otherwise: pila_activa=1, pila_push=1, pila_dato=pc+1, pc<=dir_salto, profundidad+1.
  - salto: pc<=dir_salto.
  - none: pc<=pc+1.
- ERROR: pc_valido=0, pc frozen, pila_activa=0. Exit only via reset.

Timing and arithmetic
- pila_salida reflects the top of stack at the start of the cycle. The stack updates its output on the same edge as a push/pop, so back-to-back call→ret and ret→ret need no wait state.
- Arithmetic is modulo 2^ANCHO_PC: pc=all-ones increments to 0; call at pc=all-ones pushes 0.
- Multiple inst_* high simultaneously: resolved by the priority above, with no error.
- Latency: every redirect is visible on pc the cycle after the request; there are no bubbles.

Optional Feature:
INTERRUPCION_EN
- Adds ports irq (input, 1) and inst_reti (input, 1), and parameter VECTOR_IRQ (default 4).
- Adds a mask bit, cleared by reset.

When irq=1, habilita=1, unmasked, state EJECUTA:
- irq takes priority over all inst_*.
- Pushes pc (the interrupted instruction, not pc+1), pc<=VECTOR_IRQ, depth+1, mask set.
- The same overflow rule applies.

inst_reti:
- Behaves as ret and clears the mask.
- When the mask is clear, it behaves as plain ret.

Without the macro: no irq/inst_reti ports, no mask logic.

Test Plan:
- Reset 2 cycles, then habilita=1, no inst -> pc_valido low 1 cycle in INICIO; pc sequence 0,0,1,2,3.
- pc=5, inst_call dir_salto=40; next cycle inst_ret -> push of 6 on pila_dato with pila_activa=1/pila_push=1; pc=40; then pc=6, profundidad back to 0, one pop issued.
- Three nested calls from pc 3,41,81 (targets 40,80,120), then three rets -> pc returns 82, 42, 4 in order; profundidad 3→0.
- inst_ret at profundidad=0 -> error_pila=2'b10, pc frozen, pc_valido=0, no pila_activa pulse; reset clears.
- PROFUNDIDAD=2 build: three calls -> third gives error_pila=2'b01, state ERROR, only two pushes seen.
- habilita=0 with inst_call held 4 cycles -> pc constant, pila_activa never 1; inst_salto+inst_call together -> call wins.
